// File: rtl/mpmc12_addr_gen.sv
// mpmc12 burst address generator: one aligned address per accepted beat, IDLE/RUN/DONE sequencing.
// Optional wrapping bursts are enabled by defining MPMC12_WRAP_BURST_EN.
module mpmc12_addr_gen #(
   parameter int WID  = 256,
   parameter int AWID = 30,
   parameter int LENW = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_is_write,
   input  logic [1:0]      i_mode,
   input  logic [LENW-1:0] i_burst_len,
   input  logic [31:0]     i_addr_base,
   input  logic            i_abort,
   input  logic            i_rdy,
   input  logic            i_wdf_rdy,
   output logic [31:0]     o_addr,
   output logic            o_cmd_valid,
   output logic            o_last,
   output logic [LENW-1:0] o_beat_cnt,
   output logic            o_busy,
   output logic            o_done
);
   localparam int          INC_AMT = WID / 8;
   localparam int          ALIGN   = $clog2(INC_AMT);
   localparam logic [31:0] AMASK   = 32'((64'd1 << AWID) - 64'd1);
   localparam logic [31:0] LOMASK  = 32'(INC_AMT - 1);
   localparam logic [31:0] INC     = 32'(INC_AMT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   logic [31:0]     r_addr;
   logic            r_cmd_valid;
   logic [LENW-1:0] r_beat_cnt;
   logic            r_busy;
   logic            r_done;
   logic            r_is_write;
   logic [1:0]      r_mode;
   logic [LENW-1:0] r_len;

   logic            w_accept;
   logic            w_at_end;
   logic [31:0]     w_next_addr;

   assign w_accept = r_cmd_valid & i_rdy & (r_is_write ? i_wdf_rdy : 1'b1);
   assign w_at_end = (r_beat_cnt == r_len);

`ifdef MPMC12_WRAP_BURST_EN
   logic [LENW:0] w_len_p1;
   logic          w_pow2;
   logic [31:0]   w_wmask;

   // Window mask is {len, ALIGN ones} because len+1 is a power of two.
   assign w_len_p1 = {1'b0, r_len} + 1'b1;
   assign w_pow2   = (r_len != '0) && ((w_len_p1 & {1'b0, r_len}) == '0);
   assign w_wmask  = (32'(r_len) << ALIGN) | LOMASK;
`endif

   always_comb begin
      w_next_addr = (r_addr + INC) & AMASK;
`ifdef MPMC12_WRAP_BURST_EN
      if (r_mode == 2'b10 && w_pow2)
         w_next_addr = ((r_addr & ~w_wmask) | ((r_addr + INC) & w_wmask)) & AMASK;
`endif
      if (r_mode == 2'b01)
         w_next_addr = r_addr;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_abort) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_cmd_valid <= 1'b0;
         r_beat_cnt  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_is_write  <= 1'b0;
         r_mode      <= 2'b00;
         r_len       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_is_write  <= i_is_write;
                  r_mode      <= i_mode;
                  r_len       <= i_burst_len;
                  r_addr      <= i_addr_base & AMASK & ~LOMASK;
                  r_beat_cnt  <= '0;
                  r_cmd_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_at_end) begin
                     r_cmd_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                     r_addr     <= w_next_addr;
                  end
               end
            end
            S_DONE: begin
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_addr     <= '0;
               r_beat_cnt <= '0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_addr      = r_addr;
   assign o_cmd_valid = r_cmd_valid;
   assign o_last      = r_cmd_valid & w_at_end;
   assign o_beat_cnt  = r_beat_cnt;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
endmodule

// File: tb/tb_mpmc12_addr_gen.sv
// Bench for mpmc12_addr_gen: directed and randomized bursts against an arithmetic address model.
module tb_mpmc12_addr_gen;
   localparam int      WID  = 256;
   localparam int      AWID = 30;
   localparam int      LENW = 8;
   localparam longint  INCB = WID / 8;
   localparam longint  ASPC = 64'd1 << AWID;

   logic            clk = 1'b0;
   logic            rst, start, is_write, abort, rdy, wdf_rdy;
   logic [1:0]      mode;
   logic [LENW-1:0] burst_len;
   logic [31:0]     addr_base;
   logic [31:0]     addr;
   logic            cmd_valid, last, busy, done;
   logic [LENW-1:0] beat_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mpmc12_addr_gen #(.WID(WID), .AWID(AWID), .LENW(LENW)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_is_write(is_write),
      .i_mode(mode), .i_burst_len(burst_len), .i_addr_base(addr_base),
      .i_abort(abort), .i_rdy(rdy), .i_wdf_rdy(wdf_rdy),
      .o_addr(addr), .o_cmd_valid(cmd_valid), .o_last(last),
      .o_beat_cnt(beat_cnt), .o_busy(busy), .o_done(done));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Beat k address derived directly from the burst rules.
   function automatic logic [31:0] exp_addr(input logic [1:0] md, input int len,
                                            input logic [31:0] base, input int k);
      longint al, n, win, ws;
      al = longint'(base) % ASPC;
      al = al - (al % INCB);
      n  = len + 1;
      if (md == 2'b01) return 32'(al);
`ifdef MPMC12_WRAP_BURST_EN
      if (md == 2'b10 && n > 1 && (n & (n - 1)) == 0) begin
         win = n * INCB;
         ws  = al - (al % win);
         return 32'(ws + ((al - ws + k * INCB) % win));
      end
`endif
      return 32'((al + k * INCB) % ASPC);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // wpat: 0 random stalls, 1 wdf_rdy low for first two cycles, 2 wdf_rdy always low
   task automatic run_burst(input bit wr, input logic [1:0] md, input int len,
                            input logic [31:0] base, input int stall_pct,
                            input int wpat, input bit poke);
      int k, cyc;
      bit acc;
      start = 1'b1; is_write = wr; mode = md; burst_len = LENW'(len); addr_base = base;
      rdy = 1'b1; wdf_rdy = 1'b1;
      tick();
      start = 1'b0;
      k = 0; cyc = 0;
      while (k <= len && cyc < 3000) begin
         chk("cmd_valid", {31'b0, cmd_valid}, 32'd1);
         chk("busy", {31'b0, busy}, 32'd1);
         chk("done_run", {31'b0, done}, 32'd0);
         chk("addr", addr, exp_addr(md, len, base, k));
         chk("beat_cnt", 32'(beat_cnt), 32'(k));
         chk("last", {31'b0, last}, {31'b0, (k == len)});
         rdy     = ($urandom_range(99) >= stall_pct);
         wdf_rdy = ($urandom_range(99) >= stall_pct);
         if (wpat == 1) wdf_rdy = (cyc >= 2);
         if (wpat == 2) wdf_rdy = 1'b0;
         if (poke) begin
            start = 1'b1;
            addr_base = $urandom;
            mode = 2'($urandom);
            burst_len = LENW'($urandom);
         end
         acc = rdy && (wr ? wdf_rdy : 1'b1);
         tick();
         if (acc) k++;
         cyc++;
      end
      if (cyc >= 3000) chk("burst_timeout", 32'(cyc), 32'd0);
      start = 1'b0; rdy = 1'b0; wdf_rdy = 1'b0;
      chk("done_pulse", {31'b0, done}, 32'd1);
      chk("busy_done", {31'b0, busy}, 32'd1);
      chk("cmd_valid_done", {31'b0, cmd_valid}, 32'd0);
      chk("last_done", {31'b0, last}, 32'd0);
      tick();
      chk("done_clear", {31'b0, done}, 32'd0);
      chk("busy_idle", {31'b0, busy}, 32'd0);
      chk("cmd_valid_idle", {31'b0, cmd_valid}, 32'd0);
   endtask

   initial begin
      int lens[8] = '{0, 1, 2, 3, 5, 7, 15, 255};
      int ln;
      rst = 1'b1; start = 1'b1; is_write = 1'b0; abort = 1'b0; rdy = 1'b1; wdf_rdy = 1'b1;
      mode = 2'b00; burst_len = 8'd3; addr_base = 32'h1234_5678;

      // reset held with start asserted: everything stays zero
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_outputs", {addr[27:0], cmd_valid, busy, done, last}, 32'd0);
         chk("rst_beat", 32'(beat_cnt), 32'd0);
      end
      rst = 1'b0; start = 1'b0;
      tick();
      chk("idle_cmd_valid", {31'b0, cmd_valid}, 32'd0);

      run_burst(1'b0, 2'b00, 3, 32'h1000_0013, 0, 0, 1'b0);
      run_burst(1'b1, 2'b00, 1, 32'h0000_2000, 0, 1, 1'b0);
      run_burst(1'b0, 2'b00, 1, 32'h0000_2000, 0, 2, 1'b0);
      run_burst(1'b0, 2'b10, 3, 32'h0000_1040, 0, 0, 1'b0);
      run_burst(1'b0, 2'b10, 2, 32'h0000_1040, 0, 0, 1'b0);
      run_burst(1'b0, 2'b00, 1, 32'h3FFF_FFE0, 0, 0, 1'b0);
      run_burst(1'b0, 2'b01, 2, 32'h0000_0500, 0, 0, 1'b0);
      run_burst(1'b0, 2'b11, 0, 32'hFFFF_FFFF, 0, 0, 1'b0);
      run_burst(1'b0, 2'b00, 3, 32'h0000_4000, 0, 0, 1'b1);

      // abort during beat 2 of a len=7 burst
      start = 1'b1; mode = 2'b00; burst_len = 8'd7; addr_base = 32'h0000_8000; is_write = 1'b0;
      rdy = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("abort_pre_beat", 32'(beat_cnt), 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_addr", addr, 32'd0);
      chk("abort_flags", {28'b0, cmd_valid, busy, done, last}, 32'd0);
      chk("abort_beat", 32'(beat_cnt), 32'd0);
      tick();
      chk("abort_no_done", {31'b0, done}, 32'd0);

      // randomized bursts with random back-pressure
      for (int i = 0; i < 40; i++) begin
         ln = (i % 3 == 0) ? lens[$urandom_range(7)] : int'($urandom_range(20));
         run_burst(1'($urandom), 2'($urandom), ln, $urandom, 30, 0, 1'($urandom_range(3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mpmc12_addr_gen.md
Name: mpmc12_addr_gen

Overview:
Parametrised burst address generator for the mpmc12 memory-port controller, placed between the port arbiter and the DDR user interface. It owns its burst sequencing (IDLE/RUN/DONE) rather than following the controller state. It supports configurable data width and physical address width, plus incrementing, fixed and wrapping bursts. It emits one aligned address per accepted beat, with last/done indications.

Parameters:
WID, 256, data beat width in bits; INC_AMT = WID/8 bytes per beat, ALIGN = log2(INC_AMT).
AWID, 30, physical address bits kept; addr[31:AWID] always 0.
LENW, 8, width of burst_len and beat_cnt.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin burst (sampled only in IDLE)
is_write  in  1  burst is a write (latched at start)
mode  in  2  00 INCR, 01 FIXED, 10 WRAP, 11 treated as INCR (latched at start)
burst_len  in  LENW  beats minus one (latched at start)
addr_base  in  32  byte start address (latched at start)
abort  in  1  cancel current burst
rdy  in  1  memory command ready
wdf_rdy  in  1  write-data FIFO ready
addr  out  32  current beat address
cmd_valid  out  1  addr valid for issue
last  out  1  current beat is final
beat_cnt  out  LENW  index of current beat
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Single clock; reset synchronous, active-high.
- Reset or abort: next cycle state=IDLE, addr=0, cmd_valid=0, last=0, beat_cnt=0, busy=0, done=0. Reset/abort mid-burst discards the burst with no done pulse. Abort has priority over start and accept.
- IDLE: on start=1, latch {is_write, mode, burst_len, addr_base} and go to RUN. Next cycle: addr={addr_base[AWID-1:ALIGN], ALIGN zeros}, bits ≥AWID zero; beat_cnt=0; cmd_valid=1. Latency start->first cmd_valid is 1 cycle. start is ignored outside IDLE.
- Accept = cmd_valid & rdy & (is_write ? wdf_rdy : 1). Without accept, addr/beat_cnt hold.
- RUN on accept:
  - If beat_cnt==len: go to DONE; cmd_valid=0.
  - Otherwise: beat_cnt+1; addr=next.
  - Next address by mode:
    - INCR: addr+INC_AMT, truncated to AWID bits (wraps 2^AWID-INC_AMT -> 0).
    - FIXED: addr unchanged.
    - WRAP: see Optional Feature.
- last = cmd_valid & (beat_cnt==len), combinational from registered state.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. start in DONE is ignored; earliest restart is the IDLE cycle.
- len=0: single beat with last=1 on the first cmd_valid cycle.

Optional Feature:
MPMC12_WRAP_BURST_EN
- Defined:
  - WRAP mode with len+1 in {2,4,8,16,32,64,128,256}: window mask M=(len+1)*INC_AMT-1; next addr=(addr & ~M) | ((addr+INC_AMT) & M). First beat is the aligned base, not the window start.
  - WRAP mode with len+1 not a power of two behaves as INCR.
- Undefined: mode 10 behaves as INCR; no wrap logic is synthesised.

Test Plan:
- Reset -> addr=0, cmd_valid=0, busy=0, done=0, last=0, beat_cnt=0. Hold for 3 cycles with start=1 -> outputs stay 0.
- INCR, base 0x10000013, len=3, rdy=1 -> addr 0x10000000, 0x10000020, 0x10000040, 0x10000060 on consecutive cycles. last on the 4th beat, done pulse the next cycle, then IDLE.
- Write INCR, base 0x2000, len=1, wdf_rdy low 2 cycles at beat 0 -> addr holds 0x2000 for 3 cycles, then 0x2020; read burst with wdf_rdy=0 is unaffected.
- WRAP with macro defined, base 0x1040, len=3 -> 0x1040, 0x1060, 0x1000, 0x1020. With macro undefined -> 0x1040, 0x1060, 0x1080, 0x10A0. WRAP len=2 -> INCR sequence.
- AWID=30, INCR base 0x3FFFFFE0, len=1 -> 0x3FFFFFE0, 0x00000000. FIXED base 0x500, len=2 -> 0x500 three times.
- Abort during beat 2 of len=7 -> next cycle IDLE, addr=0, no done. start pulsed during RUN of a len=3 burst -> ignored, beat sequence unchanged.
